// File: rtl/overture_fetch_pkg.sv
// overture_pkg: opcode class constants and fetch FSM encoding shared by fetch and decode.
package overture_pkg;
  localparam logic [1:0] CLS_IMM  = 2'b00;
  localparam logic [1:0] CLS_CAL  = 2'b01;
  localparam logic [1:0] CLS_COPY = 2'b10;
  localparam logic [1:0] CLS_COND = 2'b11;
  localparam int OPC_CLS_HI = 7;
  localparam int OPC_CLS_LO = 6;
  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t S_REQ   = 2'd0;
  localparam fetch_state_t S_ISSUE = 2'd1;
  localparam fetch_state_t S_HALT  = 2'd2;
endpackage

// File: rtl/overture_fetch_if.sv
// overture_fetch_if: imem read port plus decoder handshake; master is the fetch stage.
interface overture_fetch_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 8
);
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_valid;
  logic [INSTR_W-1:0] imem_data;
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               dec_ready;
  logic               branch_take;
  logic [ADDR_W-1:0]  branch_target;
  logic               halt;
  modport master (
    output imem_req, imem_addr, instr, instr_valid,
    input  imem_valid, imem_data, dec_ready, branch_take, branch_target, halt
  );
  modport slave (
    input  imem_req, imem_addr, instr, instr_valid,
    output imem_valid, imem_data, dec_ready, branch_take, branch_target, halt
  );
endinterface

// File: rtl/overture_fetch.sv
// overture_fetch: single-outstanding instruction fetch with branch redirect and halt.
// Optional OVERTURE_FETCH_STALL_CNT_EN adds a saturating 16-bit stall_cnt output.
module overture_fetch
  import overture_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int INSTR_W  = 8,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  overture_fetch_if.master  bus,
`ifdef OVERTURE_FETCH_STALL_CNT_EN
  output logic [15:0]       stall_cnt,
`endif
  output logic [ADDR_W-1:0] pc
);
  fetch_state_t       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               retire, take;
  assign retire = state_q == S_ISSUE && bus.dec_ready;
  assign take   = instr_q[OPC_CLS_HI:OPC_CLS_LO] == CLS_COND && bus.branch_take;
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (state_q == S_REQ && bus.imem_valid) begin
      instr_d = bus.imem_data;
      state_d = S_ISSUE;
    end
    if (retire) begin
      pc_d    = take ? bus.branch_target : pc_q + 1'b1;
      state_d = bus.halt ? S_HALT : S_REQ;
    end
    if (state_q == S_HALT && !bus.halt) state_d = S_REQ;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_REQ;
      pc_q    <= ADDR_W'(RESET_PC);
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end
  // Request is gated by rst so nothing is issued while reset is held.
  assign bus.imem_req    = rst && state_q == S_REQ;
  assign bus.imem_addr   = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = state_q == S_ISSUE;
  assign pc              = pc_q;
`ifdef OVERTURE_FETCH_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;
  logic        stall;
  assign stall   = (state_q == S_REQ && !bus.imem_valid) || (state_q == S_ISSUE && !bus.dec_ready);
  assign stall_d = (stall && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
  always_ff @(posedge clk) begin
    if (!rst) stall_q <= '0;
    else stall_q <= stall_d;
  end
  assign stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_overture_fetch.sv
// tb_overture_fetch: vector table of fetch/retire steps with a scoreboard queue, plus
// hand sequences for wait states, backpressure, halt and reset mid-request.
module tb_overture_fetch;
  logic clk = 0;
  logic rst = 0;
  logic [7:0] pc;
`ifdef OVERTURE_FETCH_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif
  always #5 clk = ~clk;

  overture_fetch_if #(.ADDR_W(8), .INSTR_W(8)) bus ();
  overture_fetch #(.ADDR_W(8), .INSTR_W(8), .RESET_PC(0)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
`ifdef OVERTURE_FETCH_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .pc(pc)
  );

  logic [7:0] mem [256];
  int wait_n = 0;
  int req_cnt = 0;
  always @(posedge clk) req_cnt <= (bus.imem_req && !bus.imem_valid) ? req_cnt + 1 : 0;
  assign bus.imem_valid = bus.imem_req && (req_cnt >= wait_n);
  assign bus.imem_data  = mem[bus.imem_addr];

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_valid(input int exp_cycles, input string nm);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!bus.instr_valid && n < 20);
    chk(nm, n, exp_cycles);
  endtask

  typedef struct {
    logic [7:0] addr;
    logic [7:0] op;
    logic       take;
    logic [7:0] tgt;
    logic [7:0] nxt;
  } vec_t;
  typedef struct {
    logic [7:0] addr;
    logic [7:0] op;
  } exp_t;
  vec_t vt [8];
  exp_t sbq [$];

  initial begin
    exp_t e;
    logic [7:0] snap;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    vt[0] = '{8'h00, 8'h00, 1'b1, 8'h77, 8'h01};
    vt[1] = '{8'h01, 8'h41, 1'b1, 8'h55, 8'h02};
    vt[2] = '{8'h02, 8'h82, 1'b0, 8'h00, 8'h03};
    vt[3] = '{8'h03, 8'hC1, 1'b1, 8'h20, 8'h20};
    vt[4] = '{8'h20, 8'hC1, 1'b0, 8'h90, 8'h21};
    vt[5] = '{8'h21, 8'h41, 1'b1, 8'h90, 8'h22};
    vt[6] = '{8'h22, 8'hC3, 1'b1, 8'hFF, 8'hFF};
    vt[7] = '{8'hFF, 8'h10, 1'b0, 8'h00, 8'h00};
    for (int i = 0; i < 8; i++) mem[vt[i].addr] = vt[i].op;
    bus.dec_ready = 0;
    bus.branch_take = 0;
    bus.branch_target = 0;
    bus.halt = 0;

    #1;
    chk("req_in_reset", bus.imem_req, 0);
    @(posedge clk);
    #1;
    chk("rst_pc", pc, 0);
    chk("rst_instr", bus.instr, 0);
    chk("rst_valid", bus.instr_valid, 0);
    rst = 1;
    #1;

    for (int i = 0; i < 8; i++) begin
      chk($sformatf("v%0d_req", i), bus.imem_req, 1);
      chk($sformatf("v%0d_addr", i), bus.imem_addr, vt[i].addr);
      sbq.push_back('{vt[i].addr, vt[i].op});
      wait_valid(1, $sformatf("v%0d_latency", i));
      if (sbq.size() == 0) begin
        chk("sbq_empty", 1, 0);
      end else begin
        e = sbq.pop_front();
        chk($sformatf("v%0d_instr", i), bus.instr, e.op);
        chk($sformatf("v%0d_pc", i), pc, e.addr);
      end
      bus.branch_take = vt[i].take;
      bus.branch_target = vt[i].tgt;
      bus.dec_ready = 1;
      @(posedge clk);
      #1;
      bus.dec_ready = 0;
      bus.branch_take = 1;
      bus.branch_target = 8'hEE;
      chk($sformatf("v%0d_next_pc", i), pc, vt[i].nxt);
      chk($sformatf("v%0d_valid_drop", i), bus.instr_valid, 0);
    end
    chk("tbl_sb_drained", sbq.size(), 0);
    bus.branch_take = 0;

    // three wait states: request and address held for four cycles
    wait_n = 3;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("ws_req_c%0d", c), bus.imem_req, 1);
      chk($sformatf("ws_addr_c%0d", c), bus.imem_addr, 0);
      chk($sformatf("ws_valid_c%0d", c), bus.instr_valid, 0);
      @(posedge clk);
      #1;
    end
    chk("ws_issue", bus.instr_valid, 1);
    chk("ws_instr", bus.instr, 8'h00);

    // decoder backpressure for five cycles
`ifdef OVERTURE_FETCH_STALL_CNT_EN
    begin
      logic [15:0] s0;
      s0 = stall_cnt;
`endif
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp_valid_c%0d", c), bus.instr_valid, 1);
      chk($sformatf("bp_req_c%0d", c), bus.imem_req, 0);
      chk($sformatf("bp_instr_c%0d", c), bus.instr, 8'h00);
    end
`ifdef OVERTURE_FETCH_STALL_CNT_EN
      chk("stall_delta", stall_cnt - s0, 5);
    end
`endif

    // retire with halt: no requests until halt drops, then resume at held pc
    bus.halt = 1;
    bus.dec_ready = 1;
    @(posedge clk);
    #1;
    bus.dec_ready = 0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("halt_req_c%0d", c), bus.imem_req, 0);
      chk($sformatf("halt_valid_c%0d", c), bus.instr_valid, 0);
      chk($sformatf("halt_pc_c%0d", c), pc, 1);
      @(posedge clk);
      #1;
    end
    bus.halt = 0;
    @(posedge clk);
    #1;
    chk("resume_req", bus.imem_req, 1);
    chk("resume_addr", bus.imem_addr, 1);

    // reset while the request is still waiting on memory
    @(posedge clk);
    #1;
    rst = 0;
    #1;
    chk("rstmid_req_low", bus.imem_req, 0);
    @(posedge clk);
    #1;
    chk("rstmid_pc", pc, 0);
    chk("rstmid_valid", bus.instr_valid, 0);
    rst = 1;
    #1;
    chk("rstmid_req", bus.imem_req, 1);
    chk("rstmid_addr", bus.imem_addr, 0);
    sbq.push_back('{8'h00, 8'h00});
    wait_valid(4, "rstmid_latency");
    e = sbq.pop_front();
    chk("rstmid_instr", bus.instr, e.op);
    chk("rstmid_pc_issue", pc, e.addr);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
